// File: rtl/fiat_25519_mul_share_arb_pkg.sv
// Shared definitions for the fiat_25519 shared-multiplier arbiter: default
// widths, the requester-ID width function and the response record.
package fiat_25519_mul_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DIN_W   = 32;
    localparam int DEF_DOUT_W  = 64;

    // Width needed to name one of n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_ID_W = id_width(DEF_NUM_REQ);

    // One response at the default configuration: owner ID plus product.
    typedef struct packed {
        logic [DEF_ID_W-1:0]   id;
        logic [DEF_DOUT_W-1:0] data;
    } rsp_t;

endpackage

// File: rtl/fiat_25519_mul_share_arb_if.sv
// Request/response bundle between the partial-product schedulers and the
// shared multiplier. master = requesters plus response consumer,
// slave = the arbiter.
interface fiat_25519_mul_share_arb_if
    import fiat_25519_mul_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DIN_W   = DEF_DIN_W,
    parameter int DOUT_W  = DEF_DOUT_W,
    parameter int ID_W    = id_width(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*DIN_W-1:0] req_a;
    logic [NUM_REQ*DIN_W-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [DOUT_W-1:0]        rsp_data;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/fiat_25519_mul_core.sv
// Stateless unsigned multiplier; the product is zero-extended or truncated
// to DOUT_W bits.
module fiat_25519_mul_core #(
    parameter int DIN_W  = 32,
    parameter int DOUT_W = 64
) (
    input  logic [DIN_W-1:0]  a,
    input  logic [DIN_W-1:0]  b,
    output logic [DOUT_W-1:0] p
);
    localparam int FULL_W = 2 * DIN_W;

    logic [FULL_W-1:0] full;

    assign full = FULL_W'(a) * FULL_W'(b);
    assign p    = DOUT_W'(full);

endmodule

// File: rtl/fiat_25519_rr_pick.sv
// Round-robin picker: first asserted request searching cyclically from the
// requester after last_grant. Purely combinational.
module fiat_25519_rr_pick
    import fiat_25519_mul_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_grant
);
    // Cyclic priority scan starting just after the previous winner.
    always_comb begin
        int cand;
        // NOTE: every output gets a default before the scan so no path leaves
        // it unassigned, which would otherwise infer a latch.
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last_grant) + off) % NUM_REQ;
            if (!any_grant && req[cand]) begin
                any_grant   = 1'b1;
                grant_idx   = ID_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fiat_25519_mul_share_arb.sv
// Shares one combinational multiplier among NUM_REQ requesters. A round-robin
// winner is multiplied and its product registered, with its ID, into a
// single-entry response slot that honours backpressure. The slot can be
// drained and refilled in the same cycle, giving one product per cycle.
module fiat_25519_mul_share_arb
    import fiat_25519_mul_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = id_width(NUM_REQ),
    parameter int DIN_W   = DEF_DIN_W,
    parameter int DOUT_W  = DEF_DOUT_W,
    parameter int CNT_W   = 16
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    fiat_25519_mul_share_arb_if.slave     bus,
    output logic [CNT_W-1:0]              issue_cnt
);
    // Response slot contents at this instance's widths.
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DOUT_W-1:0] data;
    } slot_t;

    logic               rsp_valid_q;
    slot_t              slot_q;
    logic [ID_W-1:0]    last_grant_q;
    logic [CNT_W-1:0]   issue_cnt_q;

    logic               can_accept;
    logic               fire;
    logic               any_grant;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [DIN_W-1:0]   op_a;
    logic [DIN_W-1:0]   op_b;
    logic [DOUT_W-1:0]  product;

    fiat_25519_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_grant  (any_grant)
    );

    fiat_25519_mul_core #(
        .DIN_W  (DIN_W),
        .DOUT_W (DOUT_W)
    ) u_core (
        .a (op_a),
        .b (op_b),
        .p (product)
    );

    // Accept when the slot is empty or being drained; route the winner's operands.
    always_comb begin
        can_accept    = !rsp_valid_q || bus.rsp_ready;
        fire          = can_accept && any_grant;
        bus.req_ready = can_accept ? grant : '0;
        op_a          = bus.req_a[int'(grant_idx)*DIN_W +: DIN_W];
        op_b          = bus.req_b[int'(grant_idx)*DIN_W +: DIN_W];
    end

    // Response slot: load on transfer, empty on drain, otherwise hold.
    always_ff @(posedge ap_clk) begin
        // NOTE: the stored product is reset as well as the valid flag, so
        // rsp_data reads zero out of reset rather than stale contents.
        if (ap_rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            rsp_valid_q <= 1'b0;
            slot_q      <= '0;
        end else if (fire) begin
            rsp_valid_q <= 1'b1;
            slot_q.id   <= grant_idx;
            slot_q.data <= product;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Round-robin pointer and wrapping issue counter advance on each transfer.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            issue_cnt_q  <= '0;
        end else if (fire) begin
            last_grant_q <= grant_idx;
            issue_cnt_q  <= issue_cnt_q + CNT_W'(1);
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = slot_q.id;
    assign bus.rsp_data  = slot_q.data;
    assign issue_cnt     = issue_cnt_q;

endmodule

// File: doc/fiat_25519_mul_share_arb.md
Name: fiat_25519_mul_share_arb

Overview:
Time-shares one combinational 32x32 unsigned multiplier core among NUM_REQ requesters in the fiat_25519 carry/square datapath, such as limb-product generators.
Arbitration is round-robin with a valid/ready handshake per requester.
Each product is registered together with the winner's ID into a single-entry response slot that honours backpressure.
This lets several partial-product schedulers use one DSP-heavy multiplier instead of one each.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester-ID width, equal to clog2(NUM_REQ)
DIN_W, 32, operand width, unsigned
DOUT_W, 64, product width; must be at least 2*DIN_W-1 (truncation to DOUT_W LSBs when narrower than 2*DIN_W)
CNT_W, 16, width of the issue counter

Ports:
ap_clk  in  1  clock, rising edge
ap_rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_a  in  NUM_REQ*DIN_W  operand A, requester i at [i*DIN_W +: DIN_W]
req_b  in  NUM_REQ*DIN_W  operand B, same packing
rsp_valid  out  1  response slot holds a product
rsp_ready  in  1  consumer accepts the response
rsp_id  out  ID_W  index of the requester that owns rsp_data
rsp_data  out  DOUT_W  registered product a*b
issue_cnt  out  CNT_W  count of accepted requests, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock ap_clk; ap_rst is synchronous and active-high.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, issue_cnt=0, last_grant=NUM_REQ-1 (requester 0 has top priority first).
- can_accept = !rsp_valid | rsp_ready (slot empty, or draining this cycle).
- Grant is combinational: the first asserted req_valid searching cyclically from last_grant+1.
  - req_ready[i] = can_accept & grant[i].
  - req_ready may depend on req_valid, within the same cycle.
  - Requesters must not make req_valid depend on req_ready.
- Transfer: req_valid[i] & req_ready[i] at edge k. After edge k:
  - rsp_valid=1, rsp_id=i, rsp_data=req_a[i]*req_b[i] (unsigned, zero-extended, DOUT_W LSBs).
  - last_grant=i.
  - issue_cnt increments by 1.
  - Latency is 1 cycle. Peak throughput is 1 product per cycle when rsp_ready is held high.
- No request accepted while the slot is full and not draining: last_grant and issue_cnt are unchanged, and no req_ready is asserted.
- Backpressure: while rsp_valid & !rsp_ready, rsp_id and rsp_data hold stable.
- Simultaneous drain and issue (rsp_valid & rsp_ready, and a grant in the same cycle): the slot is replaced by the new product and rsp_valid stays 1 with no bubble.
- Drain with no request: rsp_valid goes to 0 next cycle; rsp_data holds its last value (don't-care).
- Fairness: any continuously asserted requester is granted within NUM_REQ accepted transfers.
- Single requester active: it is granted every accepting cycle; the round-robin pointer does not starve it.
- issue_cnt wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: a pending response is discarded; outputs return to their reset values on the next edge regardless of other inputs.
- The multiplier core stays combinational with no internal state. The only timing registers are the response slot, last_grant and issue_cnt.

Decomposition:
- Shared package fiat_25519_mul_pkg holds:
  - DIN_W and DOUT_W defaults;
  - the clog2-based ID width function;
  - the response struct {id, data}.
- One sub-module, fiat_25519_rr_pick: purely combinational.
  - Inputs: request vector, last_grant.
  - Outputs: one-hot grant, grant index, any-grant flag.
- The multiplier core is instantiated unmodified with DIN_W x DIN_W -> DOUT_W.

Test Plan:
- Reset, then req_valid=4'b0001, a=0xFFFFFFFF, b=0xFFFFFFFF, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=0xFFFFFFFE00000001, issue_cnt=1.
- All four req_valid held high, with operands i+1 and 3 for requester i, rsp_ready=1 -> grant order 0,1,2,3,0; rsp_data sequence 3,6,9,12,3; one product per cycle.
- rsp_ready=0 for 5 cycles after one transfer from requester 2 (a=7, b=9) -> rsp_data=63 and rsp_id=2 held; req_ready all 0; issue_cnt unchanged; on rsp_ready=1 the next request is accepted in that same cycle.
- Only requester 3 valid for 10 cycles, rsp_ready=1 -> req_ready[3]=1 every cycle and 10 products out.
- ap_rst asserted while rsp_valid=1 and rsp_ready=0 -> next edge rsp_valid=0, rsp_data=0, issue_cnt=0; first grant after reset goes to requester 0 when all are valid.
- CNT_W=4 with 17 transfers -> issue_cnt reads 1 after the last transfer (wrap).
